// File: rtl/dispatch_ctrl_pkg.sv
// Shared definitions for the dispatch scheduler: FSM state type and
// the fixed superscalar dispatch width.
package dispatch_ctrl_pkg;

  typedef enum logic {
    DC_RUN   = 1'b0,
    DC_FLUSH = 1'b1
  } DC_STATE;

  // Fixed front-end width: at most this many instructions leave the buffer per cycle.
  localparam int DP_WIDTH = 3;

  // Smaller of two non-negative counts.
  function automatic int min_int(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/dispatch_ctrl_credit_counter.sv
// Saturating free-entry credit counter (one per back-end structure).
// Each cycle: count' = count - take + give, evaluated one bit wider than the
// counter so both overflow past MAX and underflow below 0 are visible.
// Out-of-range results clamp to the bound and raise err for that cycle.
// clear restores full credit and suppresses err.
module credit_counter #(
  parameter int MAX = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [1:0]           take,
  input  logic [1:0]           give,
  output logic [$clog2(MAX):0] count,
  output logic                 err
);

  localparam int CW = $clog2(MAX) + 1;
  localparam logic signed [CW:0] MAX_S = (CW + 1)'(MAX);

  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic signed [CW:0] sum_next;

  // Next credit value with saturation and error detection.
  always_comb begin
    sum_next   = $signed({1'b0, count_reg})
               - $signed({{(CW - 1){1'b0}}, take})
               + $signed({{(CW - 1){1'b0}}, give});
    count_next = count_reg;
    err        = 1'b0;
    if (clear) begin
      count_next = CW'(MAX);
    end else if (sum_next[CW]) begin
      count_next = '0;
      err        = 1'b1;
    end else if (sum_next > MAX_S) begin
      count_next = CW'(MAX);
      err        = 1'b1;
    end else begin
      count_next = sum_next[CW-1:0];
    end
  end

  // Credit register, full after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_reg <= CW'(MAX);
    end else begin
      count_reg <= count_next;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch scheduler for the 3-wide front end.
// Decides how many buffered instructions leave the instruction buffer each
// cycle from ROB/RS credits, drives fetch stall, and sequences buffer and
// credit recovery after a squash.
// Optional build macro DISPATCH_CTRL_STATS_EN adds three 32-bit stall /
// flush cycle counters as extra outputs.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int ROB_SZ       = 32,
  parameter int RS_SZ        = 16,
  parameter int IB_DEPTH     = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      squash,
  input  logic [$clog2(IB_DEPTH):0] ib_count,
  input  logic [1:0]                rob_retire_cnt,
  input  logic [1:0]                rs_issue_cnt,
  output logic [1:0]                dp_count,
  output logic                      ib_flush,
  output logic                      fetch_stall,
  output logic [$clog2(ROB_SZ):0]   rob_credit,
  output logic [$clog2(RS_SZ):0]    rs_credit,
  output logic                      credit_err
`ifdef DISPATCH_CTRL_STATS_EN
  ,
  output logic [31:0]               stall_rob_cyc,
  output logic [31:0]               stall_rs_cyc,
  output logic [31:0]               flush_cyc
`endif
);

  localparam int FCW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

  DC_STATE        state_reg;
  logic [FCW-1:0] flush_cnt_reg;
  logic           flush_first_reg;
  logic           credit_err_reg;

  logic           ib_illegal;
  int             ib_eff;
  logic [1:0]     dp_raw;
  logic [1:0]     rob_give;
  logic [1:0]     rs_give;
  logic           rob_err;
  logic           rs_err;

  // Clamp an illegal buffer count and pick the credit-limited dispatch width.
  always_comb begin
    ib_illegal = int'(ib_count) > IB_DEPTH;
    ib_eff     = ib_illegal ? IB_DEPTH : int'(ib_count);
    dp_raw     = 2'(min_int(min_int(ib_eff, DP_WIDTH),
                            min_int(int'(rob_credit), int'(rs_credit))));
  end

  // Combinational dispatch, flush pulse and fetch stall from state and inputs.
  always_comb begin
    dp_count    = 2'd0;
    ib_flush    = 1'b0;
    fetch_stall = 1'b1;
    if (!reset) begin
      if (state_reg == DC_RUN) begin
        if (!squash) begin
          dp_count = dp_raw;
        end
        // Keep room for a whole fetch group after this cycle's dispatch.
        fetch_stall = (ib_eff - int'(dp_count)) > (IB_DEPTH - DP_WIDTH);
      end else begin
        ib_flush = flush_first_reg;
      end
    end
  end

  // Frees only count while running; during FLUSH the credits are already full.
  always_comb begin
    rob_give = (state_reg == DC_RUN) ? rob_retire_cnt : 2'd0;
    rs_give  = (state_reg == DC_RUN) ? rs_issue_cnt   : 2'd0;
  end

  credit_counter #(.MAX(ROB_SZ)) u_rob_credit (
    .clock (clock),
    .reset (reset),
    .clear (squash),
    .take  (dp_count),
    .give  (rob_give),
    .count (rob_credit),
    .err   (rob_err)
  );

  credit_counter #(.MAX(RS_SZ)) u_rs_credit (
    .clock (clock),
    .reset (reset),
    .clear (squash),
    .take  (dp_count),
    .give  (rs_give),
    .count (rs_credit),
    .err   (rs_err)
  );

  // RUN/FLUSH sequencing, flush pulse tracking and sticky error flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= DC_RUN;
      flush_cnt_reg   <= '0;
      flush_first_reg <= 1'b0;
      credit_err_reg  <= 1'b0;
    end else begin
      // Any squash makes the following cycle the first of a (re)started flush.
      flush_first_reg <= squash;
      credit_err_reg  <= credit_err_reg | rob_err | rs_err | ib_illegal;
      case (state_reg)
        DC_RUN: begin
          if (squash) begin
            state_reg     <= DC_FLUSH;
            flush_cnt_reg <= FLUSH_LOAD;
          end
        end
        DC_FLUSH: begin
          if (squash) begin
            flush_cnt_reg <= FLUSH_LOAD;
          end else if (flush_cnt_reg == '0) begin
            state_reg <= DC_RUN;
          end else begin
            flush_cnt_reg <= flush_cnt_reg - FCW'(1);
          end
        end
        default: state_reg <= DC_RUN;
      endcase
    end
  end

  assign credit_err = credit_err_reg;

`ifdef DISPATCH_CTRL_STATS_EN
  logic [2:0]  stat_inc;
  logic [31:0] stat_reg [3];
  int          want;

  // Attribute a short dispatch to its limiter: ROB first, then RS.
  always_comb begin
    want        = min_int(ib_eff, DP_WIDTH);
    stat_inc    = 3'b000;
    if (state_reg == DC_RUN) begin
      if (!squash && ib_eff > 0) begin
        if (int'(rob_credit) < want && int'(rob_credit) <= int'(rs_credit)) begin
          stat_inc[0] = 1'b1;
        end else if (int'(rs_credit) < want) begin
          stat_inc[1] = 1'b1;
        end
      end
    end else begin
      stat_inc[2] = 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_stat
      // Free-running wrap-around event counter.
      always_ff @(posedge clock) begin
        if (reset) begin
          stat_reg[gi] <= '0;
        end else if (stat_inc[gi]) begin
          stat_reg[gi] <= stat_reg[gi] + 32'd1;
        end
      end
    end
  endgenerate

  assign stall_rob_cyc = stat_reg[0];
  assign stall_rs_cyc  = stat_reg[1];
  assign flush_cyc     = stat_reg[2];
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_dispatch_ctrl;

  localparam int ROB_SZ  = 32;
  localparam int RS_SZ   = 16;
  localparam int IB_DEP  = 16;
  localparam int FLUSH_N = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       squash = 1'b0;
  logic [4:0] ib_count = '0;
  logic [1:0] rob_retire_cnt = '0;
  logic [1:0] rs_issue_cnt = '0;
  logic [1:0] dp_count;
  logic       ib_flush;
  logic       fetch_stall;
  logic [5:0] rob_credit;
  logic [4:0] rs_credit;
  logic       credit_err;
`ifdef DISPATCH_CTRL_STATS_EN
  logic [31:0] stall_rob_cyc;
  logic [31:0] stall_rs_cyc;
  logic [31:0] flush_cyc;
`endif

  dispatch_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .squash         (squash),
    .ib_count       (ib_count),
    .rob_retire_cnt (rob_retire_cnt),
    .rs_issue_cnt   (rs_issue_cnt),
    .dp_count       (dp_count),
    .ib_flush       (ib_flush),
    .fetch_stall    (fetch_stall),
    .rob_credit     (rob_credit),
    .rs_credit      (rs_credit),
    .credit_err     (credit_err)
`ifdef DISPATCH_CTRL_STATS_EN
    ,
    .stall_rob_cyc  (stall_rob_cyc),
    .stall_rs_cyc   (stall_rs_cyc),
    .flush_cyc      (flush_cyc)
`endif
  );

  always #5 clock = ~clock;

  int n_vec  = 0;
  int n_miss = 0;
  int n_cyc  = 0;

  // Behavioural model: credits as plain integers, flush as cycles remaining.
  int m_rob, m_rs, m_left;
  bit m_err, m_first;
  int m_srob, m_srs, m_sfl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_rob = ROB_SZ; m_rs = RS_SZ; m_left = 0; m_err = 0; m_first = 0;
    m_srob = 0; m_srs = 0; m_sfl = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; squash = 1'b0; ib_count = 5'd7;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      check("rst_dp", dp_count, 0);
      check("rst_flush", ib_flush, 0);
      check("rst_stall", fetch_stall, 1);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus; compares every output with the model, then advances it.
  task automatic step(input bit sq, input int ib, input int ret, input int iss);
    int ib_e, e_dp, r;
    bit flushing, e_fl, e_st;
    @(negedge clock);
    squash = sq; ib_count = 5'(ib); rob_retire_cnt = 2'(ret); rs_issue_cnt = 2'(iss);
    #1;
    n_cyc++;
    ib_e = (ib > IB_DEP) ? IB_DEP : ib;
    flushing = (m_left > 0);
    if (flushing) begin
      e_dp = 0; e_fl = m_first; e_st = 1;
    end else begin
      e_dp = sq ? 0 : imin(imin(ib_e, 3), imin(m_rob, m_rs));
      e_fl = 0;
      e_st = (ib_e - e_dp) > (IB_DEP - 3);
    end
    check("dp_count", dp_count, e_dp);
    check("ib_flush", ib_flush, e_fl);
    check("fetch_stall", fetch_stall, e_st);
    check("rob_credit", rob_credit, m_rob);
    check("rs_credit", rs_credit, m_rs);
    check("credit_err", credit_err, m_err);
`ifdef DISPATCH_CTRL_STATS_EN
    check("stall_rob_cyc", stall_rob_cyc, m_srob);
    check("stall_rs_cyc", stall_rs_cyc, m_srs);
    check("flush_cyc", flush_cyc, m_sfl);
    if (flushing) m_sfl++;
    else if (!sq && ib_e > 0) begin
      if (m_rob < imin(ib_e, 3) && m_rob <= m_rs) m_srob++;
      else if (m_rs < imin(ib_e, 3)) m_srs++;
    end
`endif
    $display("cyc %0d sq=%0d ib=%0d ret=%0d iss=%0d -> dp=%0d fl=%0d st=%0d rob=%0d rs=%0d err=%0d",
             n_cyc, sq, ib, ret, iss, dp_count, ib_flush, fetch_stall, rob_credit, rs_credit, credit_err);
    if (ib > IB_DEP) m_err = 1;
    if (sq) begin
      m_rob = ROB_SZ; m_rs = RS_SZ; m_left = FLUSH_N; m_first = 1;
    end else if (flushing) begin
      m_left--; m_first = 0;
    end else begin
      r = m_rob - e_dp + ret;
      if (r > ROB_SZ) begin r = ROB_SZ; m_err = 1; end
      if (r < 0) begin r = 0; m_err = 1; end
      m_rob = r;
      r = m_rs - e_dp + iss;
      if (r > RS_SZ) begin r = RS_SZ; m_err = 1; end
      if (r < 0) begin r = 0; m_err = 1; end
      m_rs = r;
    end
  endtask

  initial begin
    model_reset();
    // Basic dispatch and credit consumption.
    do_reset();
    step(0, 5, 0, 0); check("t1_dp_a", dp_count, 3);
    step(0, 2, 0, 0); check("t1_dp_b", dp_count, 2);
    check("t1_rob_a", rob_credit, 29); check("t1_rs_a", rs_credit, 13);
    step(0, 0, 0, 0); check("t1_rob_b", rob_credit, 27); check("t1_rs_b", rs_credit, 11);

    // RS-limited dispatch and simultaneous free.
    do_reset();
    repeat (5) step(0, 8, 0, 0);
    step(0, 8, 0, 0); check("t2_rs1", rs_credit, 1); check("t2_dp1", dp_count, 1);
    step(0, 8, 0, 2); check("t2_rs0", rs_credit, 0); check("t2_dp0", dp_count, 0);
    step(0, 8, 0, 0); check("t2_rs2", rs_credit, 2); check("t2_dp2", dp_count, 2);

    // Squash from RUN: one flush pulse, two quiet cycles, credits refilled.
    step(1, 8, 0, 0); check("t3_sq_dp", dp_count, 0);
    step(0, 8, 1, 1); check("t3_pulse", ib_flush, 1); check("t3_dp_f1", dp_count, 0);
    check("t3_rob_full", rob_credit, 32); check("t3_rs_full", rs_credit, 16);
    step(0, 8, 1, 1); check("t3_nopulse", ib_flush, 0); check("t3_dp_f2", dp_count, 0);
    step(0, 8, 0, 0); check("t3_run_dp", dp_count, 3); check("t3_rob_hold", rob_credit, 32);

    // Squash inside FLUSH restarts the sequence.
    step(1, 8, 0, 0);
    step(0, 8, 0, 0); check("t4_pulse_a", ib_flush, 1);
    step(1, 8, 0, 0); check("t4_f2_flush", ib_flush, 0);
    step(0, 8, 0, 0); check("t4_pulse_b", ib_flush, 1); check("t4_dp_a", dp_count, 0);
    step(0, 8, 0, 0); check("t4_dp_b", dp_count, 0);
    step(0, 8, 0, 0); check("t4_run", dp_count, 3);

    // Fetch stall threshold with RS exhausted.
    do_reset();
    repeat (5) step(0, 3, 0, 0);
    step(0, 1, 0, 0);
    step(0, 14, 0, 0); check("t5_dp", dp_count, 0); check("t5_stall14", fetch_stall, 1);
    step(0, 13, 0, 0); check("t5_stall13", fetch_stall, 0);

    // Overflow saturates and the error flag sticks until reset.
    do_reset();
    step(0, 0, 3, 0);
    step(0, 0, 0, 0); check("t6_rob_sat", rob_credit, 32); check("t6_err", credit_err, 1);
    repeat (3) step(0, 0, 0, 0);
    check("t6_sticky", credit_err, 1);
    do_reset();
    check("t6_err_clr", credit_err, 0);

    // Illegal buffer count is clamped and flagged.
    step(0, 20, 0, 0); check("t7_dp", dp_count, 3); check("t7_stall", fetch_stall, 0);
    step(0, 0, 0, 0); check("t7_err", credit_err, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int ib;
      if (i % 50 == 0) do_reset();
      ib = ($urandom_range(0, 24) == 0) ? $urandom_range(17, 31) : $urandom_range(0, 16);
      step($urandom_range(0, 15) == 0, ib, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
